// File: rtl/count_event_logger_pkg.sv
// Shared types for the count event logger: event classes and wrap counter width.
package cnt_evt_pkg;

   typedef enum logic [2:0] {
      STEP_UP = 3'd0,
      STEP_DN = 3'd1,
      WRAP_UP = 3'd2,
      WRAP_DN = 3'd3,
      JUMP    = 3'd4
   } evt_type_e;

   localparam int WRAP_CNT_W = 8;

   // Packed record layout for a counter observed at the default 4-bit width.
   typedef struct packed {
      evt_type_e  etype;
      logic [3:0] cnt;
      logic       dir;
   } evt_rec4_t;

   function automatic logic is_wrap(evt_type_e t);
      return (t == WRAP_UP) || (t == WRAP_DN);
   endfunction

endpackage

// File: rtl/count_event_logger_if.sv
// Valid/ready event record port between the logger and its consumer.
interface count_event_logger_if
   import cnt_evt_pkg::*;
#(
   parameter int WIDTH = 4
);
   logic             evt_valid;
   logic             evt_ready;
   evt_type_e        evt_type;
   logic [WIDTH-1:0] evt_count;
   logic             evt_dir;

   modport master (output evt_valid, evt_type, evt_count, evt_dir, input evt_ready);
   modport slave  (input evt_valid, evt_type, evt_count, evt_dir, output evt_ready);
endinterface

// File: rtl/count_event_logger_fifo.sv
// First-word-fall-through FIFO; head data reads as zero while empty.
module evt_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         push_ok;
   logic         pop_ok;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok   = pop && !empty;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end
endmodule

// File: rtl/count_event_logger.sv
// Watches an up/down counter, classifies every change and queues one record per change.
//
//   state | meaning
//   INIT  | after reset; first sample loads prev_count, no event
//   RUN   | every change of count is classified and pushed
module count_event_logger
   import cnt_evt_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int MAX_COUNT  = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      count,
   input  logic                  updown,
   count_event_logger_if.master  evt,
   output logic [WRAP_CNT_W-1:0] wrap_cnt,
   output logic                  overflow
);
   typedef enum logic {INIT, RUN} state_e;

   typedef struct packed {
      evt_type_e        etype;
      logic [WIDTH-1:0] cnt;
      logic             dir;
   } evt_rec_t;

   localparam int REC_W = $bits(evt_rec_t);
   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

   state_e           state;
   state_e           state_nxt;
   logic [WIDTH-1:0] prev_count;
   evt_type_e        cls;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   evt_rec_t         rec_in;
   evt_rec_t         head;
   logic [REC_W-1:0] head_bits;

   always_comb begin
      cls = JUMP;
      if (prev_count == MAX_C && count == '0) begin
         cls = WRAP_UP;
      end else if (prev_count == '0 && count == MAX_C) begin
         cls = WRAP_DN;
      end else if (count == prev_count + WIDTH'(1)) begin
         cls = STEP_UP;
      end else if (count == prev_count - WIDTH'(1)) begin
         cls = STEP_DN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= INIT;
         prev_count <= '0;
      end else begin
         state      <= state_nxt;
         prev_count <= count;
      end
   end

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      case (state)
         INIT: state_nxt = RUN;
         RUN:  push      = (count != prev_count);
         default: state_nxt = INIT;
      endcase
   end

   assign rec_in = '{etype: cls, cnt: count, dir: updown};
   assign pop    = !empty && evt.evt_ready;

   evt_fifo #(
      .W     (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (rec_in),
      .pop       (pop),
      .pop_data  (head_bits),
      .full      (full),
      .empty     (empty)
   );

   assign head          = evt_rec_t'(head_bits);
   assign evt.evt_valid = !empty;
   assign evt.evt_type  = head.etype;
   assign evt.evt_count = head.cnt;
   assign evt.evt_dir   = head.dir;

   // Wraps count even when the record itself is dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wrap_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (push && is_wrap(cls) && wrap_cnt != '1) begin
            wrap_cnt <= wrap_cnt + 1'b1;
         end
         if (push && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_count_event_logger.sv
// Directed and randomized checks of count_event_logger against a queue-based reference model.
module tb_count_event_logger;
   import cnt_evt_pkg::*;

   localparam int WIDTH     = 4;
   localparam int MAX_COUNT = 6;
   localparam int DEPTH     = 4;
   localparam int MODULUS   = 1 << WIDTH;

   typedef struct {
      int t;
      int c;
      int d;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] count = '0;
   logic       updown = 1'b0;
   logic [7:0] wrap_cnt;
   logic       overflow;

   int tests = 0;
   int fails = 0;

   rec_t q[$];
   bit   m_run = 0;
   int   m_prev = 0;
   int   m_wrap = 0;
   bit   m_ovf = 0;
   bit   just_reset = 0;

   count_event_logger_if #(.WIDTH(WIDTH)) evt ();

   count_event_logger #(
      .WIDTH      (WIDTH),
      .MAX_COUNT  (MAX_COUNT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .count    (count),
      .updown   (updown),
      .evt      (evt),
      .wrap_cnt (wrap_cnt),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   function automatic int classify(int p, int c);
      if (p == MAX_COUNT && c == 0) return 2;
      if (p == 0 && c == MAX_COUNT) return 3;
      if (c == (p + 1) % MODULUS) return 0;
      if (c == (p + MODULUS - 1) % MODULUS) return 1;
      return 4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input int exp);
      tests++;
      assert (got === 32'(exp)) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_edge(input int c, input bit ud, input bit rdy, input bit rb);
      bit   pop;
      bit   was_full;
      rec_t r;
      if (!rb) begin
         q.delete();
         m_run = 0;
         m_prev = 0;
         m_wrap = 0;
         m_ovf = 0;
         just_reset = 1;
         return;
      end
      just_reset = 0;
      pop = (q.size() > 0) && rdy;
      was_full = (q.size() == DEPTH);
      if (pop) void'(q.pop_front());
      if (m_run && c != m_prev) begin
         r.t = classify(m_prev, c);
         r.c = c;
         r.d = ud;
         if (!was_full || pop) q.push_back(r);
         else m_ovf = 1;
         if (r.t == 2 || r.t == 3) m_wrap = (m_wrap < 255) ? m_wrap + 1 : 255;
      end
      m_run = 1;
      m_prev = c;
   endtask

   task automatic check_outputs();
      chk("evt_valid", evt.evt_valid, (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) begin
         chk("evt_type", evt.evt_type, q[0].t);
         chk("evt_count", evt.evt_count, q[0].c);
         chk("evt_dir", evt.evt_dir, q[0].d);
      end else if (just_reset) begin
         chk("rst_evt_type", evt.evt_type, 0);
         chk("rst_evt_count", evt.evt_count, 0);
         chk("rst_evt_dir", evt.evt_dir, 0);
      end
      chk("wrap_cnt", wrap_cnt, m_wrap);
      chk("overflow", overflow, m_ovf);
   endtask

   task automatic step(input int c, input bit ud, input bit rdy, input bit rb);
      @(negedge clk);
      count = 4'(c);
      updown = ud;
      evt.evt_ready = rdy;
      rst = rb;
      @(posedge clk);
      model_edge(c, ud, rdy, rb);
      #1;
      check_outputs();
   endtask

   task automatic expect_head(input string tag, input int t, input int c, input int d);
      chk({tag, "_valid"}, evt.evt_valid, 1);
      chk({tag, "_type"}, evt.evt_type, t);
      chk({tag, "_count"}, evt.evt_count, c);
      chk({tag, "_dir"}, evt.evt_dir, d);
   endtask

   initial begin
      int c;
      int r;
      evt.evt_ready = 1'b1;

      // reset, then first sample is silent and steps follow with 1-cycle latency
      step(0, 1, 1, 0);
      step(0, 1, 1, 0);
      chk("reset_valid", evt.evt_valid, 0);
      chk("reset_wrap", wrap_cnt, 0);
      chk("reset_ovf", overflow, 0);
      step(0, 1, 1, 1);
      chk("first_sample", evt.evt_valid, 0);
      step(1, 1, 1, 1);
      expect_head("t1_up1", 0, 1, 1);
      step(2, 1, 1, 1);
      expect_head("t1_up2", 0, 2, 1);

      // wrap up
      step(5, 1, 1, 1);
      step(6, 1, 1, 1);
      expect_head("t2_up6", 0, 6, 1);
      step(0, 1, 1, 1);
      expect_head("t2_wrapup", 2, 0, 1);
      chk("t2_wrap_cnt", wrap_cnt, 1);

      // wrap down
      step(1, 0, 1, 1);
      step(0, 0, 1, 1);
      expect_head("t3_dn0", 1, 0, 0);
      step(6, 0, 1, 1);
      expect_head("t3_wrapdn", 3, 6, 0);
      chk("t3_wrap_cnt", wrap_cnt, 2);

      // back-pressure overflow then drain
      step(0, 1, 1, 1);
      step(0, 1, 1, 1);
      chk("t4_empty", evt.evt_valid, 0);
      for (int i = 1; i <= 6; i++) step(i, 1, 0, 1);
      chk("t4_ovf", overflow, 1);
      expect_head("t4_head1", 0, 1, 1);
      for (int k = 2; k <= 4; k++) begin
         step(6, 1, 1, 1);
         expect_head("t4_drain", 0, k, 1);
      end
      step(6, 1, 1, 1);
      chk("t4_drained", evt.evt_valid, 0);

      // full FIFO with push and pop on the same edge
      step(6, 1, 1, 0);
      step(0, 1, 0, 1);
      for (int i = 1; i <= 4; i++) step(i, 1, 0, 1);
      expect_head("t5_full_head", 0, 1, 1);
      step(5, 1, 1, 1);
      chk("t5_no_ovf", overflow, 0);
      for (int k = 2; k <= 5; k++) begin
         expect_head("t5_order", 0, k, 1);
         step(5, 1, 1, 1);
      end
      chk("t5_drained", evt.evt_valid, 0);

      // jump, then reset with records queued
      step(6, 1, 1, 1);
      step(0, 1, 1, 1);
      step(3, 1, 1, 1);
      step(0, 1, 1, 1);
      expect_head("t6_jump", 4, 0, 1);
      step(1, 1, 0, 1);
      step(2, 1, 0, 1);
      chk("t6_pre_wrap", wrap_cnt, 1);
      step(2, 1, 0, 0);
      chk("t6_rst_valid", evt.evt_valid, 0);
      chk("t6_rst_wrap", wrap_cnt, 0);
      chk("t6_rst_ovf", overflow, 0);
      step(4, 1, 1, 1);
      chk("t6_first_sample", evt.evt_valid, 0);

      // wrap counter saturation
      step(0, 1, 1, 1);
      for (int i = 0; i < 300; i++) step((i % 2 == 0) ? MAX_COUNT : 0, i % 2, 1, 1);
      chk("sat_wrap", wrap_cnt, 255);

      // randomized traffic
      c = 0;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: c = (c + 1) % MODULUS;
            3, 4:    c = (c + MODULUS - 1) % MODULUS;
            5:       c = c;
            6:       c = MAX_COUNT;
            7:       c = 0;
            default: c = $urandom_range(0, MODULUS - 1);
         endcase
         step(c, r < 3, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
